// File: rtl/riscv_commit_trace.sv
// Retirement-trace capture: classifies, numbers and buffers commit records.
// Optional TRACE_FILTER_EN adds a per-kind capture mask input.
module riscv_commit_trace #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = 16,
    parameter int DROP_W = 8
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      flush_i,
    input  logic                      ret_valid_i,
    input  logic [XLEN-1:0]           ret_pc_i,
    input  logic [XLEN-1:0]           ret_instr_i,
    input  logic [XLEN-1:0]           ret_wdata_i,
    input  logic [XLEN-1:0]           ret_maddr_i,
    input  logic [XLEN-1:0]           ret_mdata_i,
`ifdef TRACE_FILTER_EN
    input  logic [4:0]                filter_mask_i,
`endif
    input  logic                      tr_ready_i,
    output logic                      tr_valid_o,
    output logic [SEQ_W-1:0]          tr_seq_o,
    output logic [XLEN-1:0]           tr_pc_o,
    output logic [XLEN-1:0]           tr_instr_o,
    output logic [2:0]                tr_kind_o,
    output logic [4:0]                tr_rd_o,
    output logic                      tr_rd_we_o,
    output logic [XLEN-1:0]           tr_wdata_o,
    output logic [XLEN-1:0]           tr_maddr_o,
    output logic [XLEN-1:0]           tr_mdata_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [DROP_W-1:0]         drop_cnt_o,
    output logic                      halt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [2:0] K_OTHER  = 3'd0;
    localparam logic [2:0] K_LOAD   = 3'd1;
    localparam logic [2:0] K_STORE  = 3'd2;
    localparam logic [2:0] K_REGWR  = 3'd3;
    localparam logic [2:0] K_BRANCH = 3'd4;

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
        logic [2:0]       kind;
        logic [4:0]       rd;
        logic             rd_we;
        logic [XLEN-1:0]  wdata;
        logic [XLEN-1:0]  maddr;
        logic [XLEN-1:0]  mdata;
    } rec_t;

    rec_t              mem [DEPTH];
    rec_t              in_rec;
    rec_t              out_rec;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [SEQ_W-1:0]  seq;
    logic [DROP_W-1:0] drop_cnt;
    logic [0:0]        state;
    logic [2:0]        kind;
    logic              has_rd;
    logic              is_mem;
    logic              halt_rec;
    logic              eligible;
    logic              accept;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    always_comb begin
        kind = K_OTHER;
        unique case (ret_instr_i[6:0])
            7'b0000011: kind = K_LOAD;
            7'b0100011: kind = K_STORE;
            7'b1100011: kind = K_BRANCH;
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: kind = K_REGWR;
            default: kind = K_OTHER;
        endcase
    end

    assign has_rd   = (kind == K_LOAD) || (kind == K_REGWR);
    assign is_mem   = (kind == K_LOAD) || (kind == K_STORE);
    assign halt_rec = (ret_instr_i == '0);

    always_comb begin
        in_rec       = '0;
        in_rec.seq   = seq;
        in_rec.pc    = ret_pc_i;
        in_rec.instr = ret_instr_i;
        in_rec.kind  = kind;
        in_rec.rd    = has_rd ? ret_instr_i[11:7] : 5'd0;
        in_rec.rd_we = has_rd && (ret_instr_i[11:7] != 5'd0);
        in_rec.wdata = in_rec.rd_we ? ret_wdata_i : '0;
        in_rec.maddr = is_mem ? ret_maddr_i : '0;
        in_rec.mdata = is_mem ? ret_mdata_i : '0;
    end

`ifdef TRACE_FILTER_EN
    assign eligible = filter_mask_i[kind] || halt_rec;
`else
    assign eligible = 1'b1;
`endif

    assign accept     = ret_valid_i && (state == RUN);
    assign full       = (count == FULL_CNT);
    assign tr_valid_o = (count != '0);
    assign pop        = tr_valid_o && tr_ready_i;
    assign push       = accept && eligible && (!full || pop);
    assign drop       = accept && eligible && full && !pop;

    // Data outputs read zero whenever the FIFO is empty.
    assign out_rec    = tr_valid_o ? mem[rd_ptr] : '0;
    assign tr_seq_o   = out_rec.seq;
    assign tr_pc_o    = out_rec.pc;
    assign tr_instr_o = out_rec.instr;
    assign tr_kind_o  = out_rec.kind;
    assign tr_rd_o    = out_rec.rd;
    assign tr_rd_we_o = out_rec.rd_we;
    assign tr_wdata_o = out_rec.wdata;
    assign tr_maddr_o = out_rec.maddr;
    assign tr_mdata_o = out_rec.mdata;
    assign count_o    = count;
    assign drop_cnt_o = drop_cnt;
    assign halt_o     = (state == HALTED);

    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem[wr_ptr] <= in_rec;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            seq      <= '0;
            drop_cnt <= '0;
            state    <= RUN;
        end else if (flush_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            seq      <= '0;
            drop_cnt <= '0;
            state    <= RUN;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (accept) begin
                seq <= seq + SEQ_W'(1);
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
            if (accept && halt_rec) begin
                state <= HALTED;
            end
        end
    end
endmodule

// File: tb/tb_riscv_commit_trace.sv
// Directed bench for riscv_commit_trace with a record scoreboard.
// Build with TRACE_FILTER_EN to add the capture-mask step.
module tb_riscv_commit_trace;
    localparam int DEPTH = 8;

    localparam logic [31:0] ADDI = 32'h0010_0293;
    localparam logic [31:0] SW   = 32'h00A5_A023;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] LW0  = 32'h0000_2003;
    localparam logic [31:0] LW5  = 32'h0000_2283;

    typedef struct {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  kind;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wd;
        logic [31:0] ma;
        logic [31:0] md;
    } rec_t;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wdata;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic [4:0]  fmask;
    logic        ready;
    logic        tr_valid;
    logic [15:0] tr_seq;
    logic [31:0] tr_pc;
    logic [31:0] tr_instr;
    logic [2:0]  tr_kind;
    logic [4:0]  tr_rd;
    logic        tr_rd_we;
    logic [31:0] tr_wdata;
    logic [31:0] tr_maddr;
    logic [31:0] tr_mdata;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;
    logic        halt;

    rec_t q[$];
    int   mseq;
    int   mdrop;
    bit   mhalt;
    int   npass;
    int   ntotal;

    riscv_commit_trace dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .flush_i      (flush),
        .ret_valid_i  (valid),
        .ret_pc_i     (pc),
        .ret_instr_i  (instr),
        .ret_wdata_i  (wdata),
        .ret_maddr_i  (maddr),
        .ret_mdata_i  (mdata),
`ifdef TRACE_FILTER_EN
        .filter_mask_i(fmask),
`endif
        .tr_ready_i   (ready),
        .tr_valid_o   (tr_valid),
        .tr_seq_o     (tr_seq),
        .tr_pc_o      (tr_pc),
        .tr_instr_o   (tr_instr),
        .tr_kind_o    (tr_kind),
        .tr_rd_o      (tr_rd),
        .tr_rd_we_o   (tr_rd_we),
        .tr_wdata_o   (tr_wdata),
        .tr_maddr_o   (tr_maddr),
        .tr_mdata_o   (tr_mdata),
        .count_o      (count),
        .drop_cnt_o   (drop_cnt),
        .halt_o       (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic rec_t mkrec();
        rec_t r;
        bit   hr;
        bit   mm;
        r.seq   = 16'(mseq);
        r.pc    = pc;
        r.instr = instr;
        case (instr[6:0])
            7'b0000011: r.kind = 3'd1;
            7'b0100011: r.kind = 3'd2;
            7'b1100011: r.kind = 3'd4;
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: r.kind = 3'd3;
            default: r.kind = 3'd0;
        endcase
        hr   = (r.kind == 3'd1) || (r.kind == 3'd3);
        mm   = (r.kind == 3'd1) || (r.kind == 3'd2);
        r.rd = hr ? instr[11:7] : 5'd0;
        r.we = hr && (instr[11:7] != 5'd0);
        r.wd = r.we ? wdata : 32'd0;
        r.ma = mm ? maddr : 32'd0;
        r.md = mm ? mdata : 32'd0;
        return r;
    endfunction

    task automatic cycle();
        bit   pop;
        bit   elig;
        bit   do_push;
        rec_t r;
        chk("valid", tr_valid, q.size() != 0);
        chk("count", count, q.size());
        chk("drop", drop_cnt, mdrop);
        chk("halt", halt, mhalt);
        if (q.size() != 0) begin
            chk("seq", tr_seq, q[0].seq);
            chk("pc", tr_pc, q[0].pc);
            chk("instr", tr_instr, q[0].instr);
            chk("kind", tr_kind, q[0].kind);
            chk("rd", tr_rd, q[0].rd);
            chk("rd_we", tr_rd_we, q[0].we);
            chk("wdata", tr_wdata, q[0].wd);
            chk("maddr", tr_maddr, q[0].ma);
            chk("mdata", tr_mdata, q[0].md);
        end else begin
            chk("idle_pc", tr_pc, 0);
            chk("idle_seq", tr_seq, 0);
        end
        pop     = (q.size() != 0) && ready;
        do_push = 1'b0;
        if (flush) begin
            q.delete();
            mseq  = 0;
            mdrop = 0;
            mhalt = 1'b0;
        end else begin
            if (valid && !mhalt) begin
                r    = mkrec();
`ifdef TRACE_FILTER_EN
                elig = fmask[r.kind] || (instr == 32'd0);
`else
                elig = 1'b1;
`endif
                if (elig) begin
                    if (q.size() < DEPTH || pop) do_push = 1'b1;
                    else if (mdrop < 255) mdrop++;
                end
                if (instr == 32'd0) mhalt = 1'b1;
                mseq = (mseq + 1) % 65536;
            end
            if (pop) void'(q.pop_front());
            if (do_push) q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ret(input logic [31:0] p, input logic [31:0] i,
                       input logic [31:0] wd, input logic [31:0] ma,
                       input logic [31:0] md);
        valid = 1'b1;
        pc    = p;
        instr = i;
        wdata = wd;
        maddr = ma;
        mdata = md;
        cycle();
        valid = 1'b0;
    endtask

    task automatic drain(input int n);
        ready = 1'b1;
        repeat (n) cycle();
        ready = 1'b0;
    endtask

    initial begin
        npass  = 0;
        ntotal = 0;
        mseq   = 0;
        mdrop  = 0;
        mhalt  = 1'b0;
        rstn   = 1'b0;
        flush  = 1'b0;
        valid  = 1'b0;
        pc     = '0;
        instr  = '0;
        wdata  = '0;
        maddr  = '0;
        mdata  = '0;
        fmask  = 5'b11111;
        ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", tr_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_halt", halt, 0);
        chk("rst_wdata", tr_wdata, 0);
        rstn = 1'b1;
        cycle();

        // step 1: three mixed retires, consumer always ready
        ready = 1'b1;
        ret(32'h0, ADDI, 32'h1, 32'h0, 32'h0);
        chk("s1_kind0", tr_kind, 3);
        chk("s1_we0", tr_rd_we, 1);
        ret(32'h4, SW, 32'h55, 32'h100, 32'hAB);
        chk("s1_kind1", tr_kind, 2);
        chk("s1_maddr1", tr_maddr, 32'h100);
        ret(32'h8, BEQ, 32'h0, 32'h0, 32'h0);
        chk("s1_seq2", tr_seq, 2);
        chk("s1_kind2", tr_kind, 4);
        drain(3);

        // step 2: overflow with a stalled consumer
        for (int i = 0; i < DEPTH + 3; i++) begin
            ret(32'h100 + 32'(4 * i), ADDI, 32'(i), 32'h0, 32'h0);
        end
        cycle();
        chk("s2_count", count, DEPTH);
        chk("s2_drop", drop_cnt, 3);
        chk("s2_seq", tr_seq, 3);
        drain(DEPTH + 1);

        // step 3: retire and pop together while full
        for (int i = 0; i < DEPTH; i++) begin
            ret(32'h200 + 32'(4 * i), LW5, 32'(i), 32'h300, 32'(i));
        end
        ready = 1'b1;
        ret(32'h2F0, SW, 32'h0, 32'h400, 32'hCD);
        ready = 1'b0;
        chk("s3_count", count, DEPTH);
        chk("s3_drop", drop_cnt, 3);
        drain(DEPTH + 1);

        // step 4: halt record, ignored retires, flush
        ret(32'h40, 32'h0, 32'h0, 32'h0, 32'h0);
        ret(32'h44, ADDI, 32'h0, 32'h0, 32'h0);
        ret(32'h48, ADDI, 32'h0, 32'h0, 32'h0);
        cycle();
        chk("s4_halt", halt, 1);
        chk("s4_count", count, 1);
        chk("s4_pc", tr_pc, 32'h40);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("s4_fl_halt", halt, 0);
        chk("s4_fl_count", count, 0);
        ret(32'h50, ADDI, 32'h7, 32'h0, 32'h0);
        chk("s4_seq0", tr_seq, 0);
        drain(2);

        // step 5: lw x0 then drop-counter saturation
        ret(32'h10, LW0, 32'h1234, 32'h10, 32'h99);
        chk("s5_kind", tr_kind, 1);
        chk("s5_rd", tr_rd, 0);
        chk("s5_we", tr_rd_we, 0);
        chk("s5_wdata", tr_wdata, 0);
        for (int i = 0; i < 307; i++) begin
            ret(32'h1000 + 32'(4 * i), ADDI, 32'(i), 32'h0, 32'h0);
        end
        cycle();
        chk("s5_drop_sat", drop_cnt, 255);
        flush = 1'b1;
        cycle();
        flush = 1'b0;

`ifdef TRACE_FILTER_EN
        // step 6: capture only loads
        fmask = 5'b00010;
        ret(32'h60, ADDI, 32'h1, 32'h0, 32'h0);
        ret(32'h64, LW5, 32'h2, 32'h80, 32'h2);
        ret(32'h68, SW, 32'h0, 32'h84, 32'h3);
        cycle();
        chk("s6_count", count, 1);
        chk("s6_seq", tr_seq, 1);
        chk("s6_drop", drop_cnt, 0);
        drain(2);
        fmask = 5'b11111;
`endif

        // asynchronous reset with records in flight
        ret(32'h70, ADDI, 32'h1, 32'h0, 32'h0);
        ret(32'h74, ADDI, 32'h2, 32'h0, 32'h0);
        rstn = 1'b0;
        #1;
        chk("arst_valid", tr_valid, 0);
        chk("arst_count", count, 0);
        q.delete();
        mseq  = 0;
        mdrop = 0;
        mhalt = 1'b0;
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        ret(32'h80, ADDI, 32'h3, 32'h0, 32'h0);
        chk("arst_seq", tr_seq, 0);
        drain(2);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
